data_island_packet_assembler: RTL and testbench

Serialises one HDMI data-island packet (24-bit header, four 56-bit subpackets) into 32 consecutive TMDS data-island symbols, one per pixel clock. It sits directly downstream of the packet generators (audio clock regeneration, audio sample, InfoFrames) and their packet picker, and directly upstream of the TERC4 encoders. It computes the BCH(32,24) header parity and the four BCH(64,56) subpacket parities serially and inserts them in the last cycles of each packet.

---
 rtl/data_island_packet_assembler.sv | 129 ++++++++++++
 tb/tb_data_island_packet_assembler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_island_packet_assembler.sv
// Serialises one HDMI data-island packet (header + four subpackets) into 32 symbols,
// inserting serially computed BCH parity. Optional parity outputs: DATA_ISLAND_PARITY_OUT_EN.
module data_island_packet_assembler (
   input  logic              clk_pixel,
   input  logic              reset,
   input  logic              data_island_period,
   input  logic [23:0]       header,
   input  logic [3:0][55:0]  sub,
   output logic              packet_load,
   output logic [4:0]        counter,
   output logic [8:0]        packet_data,
`ifdef DATA_ISLAND_PARITY_OUT_EN
   output logic [7:0]        header_parity,
   output logic [31:0]       sub_parity,
`endif
   output logic              packet_end
);

   logic [4:0]       counter_q, counter_d;
   logic [23:0]      header_q;
   logic [3:0][55:0] sub_q;
   logic [7:0]       hecc_q, hecc_d;
   logic [3:0][7:0]  secc_q, secc_d;
   logic [8:0]       packet_data_q, packet_data_d;
   logic             packet_end_q, packet_end_d;

   logic [23:0]      hdr_cur;
   logic [3:0][55:0] sub_cur;
   logic             hbit;
   logic [3:0]       even_bit, odd_bit, ch1, ch2;
   logic             ch0;

   function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic b);
      logic f;
      f = b ^ ecc[0];
      return (ecc >> 1) ^ (f ? 8'h83 : 8'h00);
   endfunction

   assign packet_load = data_island_period && (counter_q == 5'd0);

   always_comb begin
      // Bit 0 comes from the live inputs; later bits from the shadow copy.
      hdr_cur  = packet_load ? header : header_q;
      sub_cur  = packet_load ? sub : sub_q;
      hbit     = (counter_q < 5'd24) ? hdr_cur[counter_q] : 1'b0;
      even_bit = '0;
      odd_bit  = '0;
      ch1      = '0;
      ch2      = '0;
      for (int i = 0; i < 4; i++) begin
         if (counter_q < 5'd28) begin
            even_bit[i] = sub_cur[i][{counter_q, 1'b0}];
            odd_bit[i]  = sub_cur[i][{counter_q, 1'b1}];
            ch1[i]      = even_bit[i];
            ch2[i]      = odd_bit[i];
         end else begin
            ch1[i] = secc_q[i][{counter_q[1:0], 1'b0}];
            ch2[i] = secc_q[i][{counter_q[1:0], 1'b1}];
         end
      end
      ch0 = (counter_q < 5'd24) ? hbit : hecc_q[counter_q[2:0]];

      hecc_d = hecc_q;
      secc_d = secc_q;
      if (packet_load) begin
         hecc_d = ecc_step(8'h00, hbit);
         for (int i = 0; i < 4; i++) begin
            secc_d[i] = ecc_step(ecc_step(8'h00, even_bit[i]), odd_bit[i]);
         end
      end else if (data_island_period) begin
         if (counter_q < 5'd24) hecc_d = ecc_step(hecc_q, hbit);
         if (counter_q < 5'd28) begin
            for (int i = 0; i < 4; i++) begin
               secc_d[i] = ecc_step(ecc_step(secc_q[i], even_bit[i]), odd_bit[i]);
            end
         end
      end

      counter_d     = data_island_period ? counter_q + 5'd1 : 5'd0;
      packet_data_d = data_island_period ? {ch2, ch1, ch0} : 9'd0;
      packet_end_d  = data_island_period && (counter_q == 5'd31);
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         counter_q     <= 5'd0;
         header_q      <= '0;
         sub_q         <= '0;
         hecc_q        <= '0;
         secc_q        <= '0;
         packet_data_q <= 9'd0;
         packet_end_q  <= 1'b0;
      end else begin
         counter_q     <= counter_d;
         hecc_q        <= hecc_d;
         secc_q        <= secc_d;
         packet_data_q <= packet_data_d;
         packet_end_q  <= packet_end_d;
         if (packet_load) begin
            header_q <= header;
            sub_q    <= sub;
         end
      end
   end

`ifdef DATA_ISLAND_PARITY_OUT_EN
   logic [7:0]  header_parity_q;
   logic [31:0] sub_parity_q;

   // Parity is final at index 31, so it lands together with packet_end.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         header_parity_q <= '0;
         sub_parity_q    <= '0;
      end else if (packet_end_d) begin
         header_parity_q <= hecc_q;
         sub_parity_q    <= secc_q;
      end
   end

   assign header_parity = header_parity_q;
   assign sub_parity    = sub_parity_q;
`endif

   assign counter     = counter_q;
   assign packet_data = packet_data_q;
   assign packet_end  = packet_end_q;

endmodule

// File: tb/tb_data_island_packet_assembler.sv
// Randomised/directed bench for data_island_packet_assembler against a stream-level model.
module tb_data_island_packet_assembler;

   logic             clk_pixel = 1'b0;
   logic             reset;
   logic             data_island_period;
   logic [23:0]      header;
   logic [3:0][55:0] sub;
   logic             packet_load;
   logic [4:0]       counter;
   logic [8:0]       packet_data;
   logic             packet_end;
`ifdef DATA_ISLAND_PARITY_OUT_EN
   logic [7:0]       header_parity;
   logic [31:0]      sub_parity;
`endif

   int nvec = 0;
   int nerr = 0;

   data_island_packet_assembler dut (
      .clk_pixel          (clk_pixel),
      .reset              (reset),
      .data_island_period (data_island_period),
      .header             (header),
      .sub                (sub),
      .packet_load        (packet_load),
      .counter            (counter),
      .packet_data        (packet_data),
`ifdef DATA_ISLAND_PARITY_OUT_EN
      .header_parity      (header_parity),
      .sub_parity         (sub_parity),
`endif
      .packet_end         (packet_end)
   );

   always #5 clk_pixel = ~clk_pixel;

   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // BCH parity over the first n bits of d, LSB first.
   function automatic logic [7:0] bch(input logic [63:0] d, input int n);
      logic [7:0] e;
      logic       f;
      e = 8'h00;
      for (int i = 0; i < n; i++) begin
         f = d[i] ^ e[0];
         e = (e >> 1) ^ (f ? 8'h83 : 8'h00);
      end
      return e;
   endfunction

   function automatic logic [8:0] model_sym(input logic [23:0] h, input logic [3:0][55:0] s,
                                            input int k);
      logic [31:0] hs;
      logic [63:0] ss;
      logic [8:0]  r;
      hs   = {bch(64'(h), 24), h};
      r[0] = hs[k];
      for (int i = 0; i < 4; i++) begin
         ss       = {bch(64'(s[i]), 56), s[i]};
         r[1 + i] = ss[2 * k];
         r[5 + i] = ss[2 * k + 1];
      end
      return r;
   endfunction

   function automatic logic [3:0][55:0] rnd_sub();
      logic [3:0][55:0] s;
      for (int i = 0; i < 4; i++) s[i] = 56'({$urandom, $urandom});
      return s;
   endfunction

   // Presents a packet at the load cycle, then checks nsym symbols.
   task automatic run_packet(input logic [23:0] h, input logic [3:0][55:0] s,
                             input bit scramble, input int nsym, input int hp_exp);
      logic [7:0] hp_obs;
      hp_obs = 8'h00;
      header = h;
      sub = s;
      data_island_period = 1'b1;
      #1;
      chk("load_at_0", 64'(packet_load), 64'd1);
      chk("counter_at_load", 64'(counter), 64'd0);
      for (int k = 0; k < nsym; k++) begin
         tick();
         if (scramble) begin
            header = 24'($urandom);
            sub = rnd_sub();
         end
         chk("symbol", 64'(packet_data), 64'(model_sym(h, s, k)));
         chk("packet_end", 64'(packet_end), 64'(k == 31));
         chk("counter", 64'(counter), 64'((k + 1) % 32));
         if (k >= 24 && k <= 31) hp_obs[k - 24] = packet_data[0];
      end
      if (nsym == 32 && hp_exp >= 0) chk("hdr_parity_bits", 64'(hp_obs), 64'(hp_exp));
`ifdef DATA_ISLAND_PARITY_OUT_EN
      if (nsym == 32) begin
         chk("header_parity", 64'(header_parity), 64'(bch(64'(h), 24)));
         chk("sub_parity", 64'(sub_parity),
             64'({bch(64'(s[3]), 56), bch(64'(s[2]), 56), bch(64'(s[1]), 56),
                  bch(64'(s[0]), 56)}));
      end
`endif
   endtask

   logic [3:0][55:0] zs;
   logic [3:0][55:0] s2;

   initial begin
      zs = '0;
      reset = 1'b1;
      data_island_period = 1'b0;
      header = '0;
      sub = '0;
      #2;
      chk("rst_counter", 64'(counter), 64'd0);
      chk("rst_data", 64'(packet_data), 64'd0);
      chk("rst_end", 64'(packet_end), 64'd0);
      chk("rst_load", 64'(packet_load), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("idle_counter", 64'(counter), 64'd0);

      // All-zero packets back to back.
      run_packet(24'h0, zs, 1'b0, 32, 0);
      run_packet(24'h0, zs, 1'b0, 32, 0);

      // Header bit 0 only: parity 8'h4A.
      run_packet(24'h000001, zs, 1'b0, 32, 8'h4A);
`ifdef DATA_ISLAND_PARITY_OUT_EN
      chk("header_parity_4a", 64'(header_parity), 64'h4A);
`endif

      // Single bit in subpacket 2.
      s2 = zs;
      s2[2] = 56'h1;
      run_packet(24'h0, s2, 1'b0, 32, -1);

      // Random packets with inputs churning after load.
      for (int p = 0; p < 6; p++) begin
         run_packet(24'($urandom), rnd_sub(), 1'b1, 32, -1);
      end

      // Island closes mid-packet at counter 17.
      run_packet(24'($urandom), rnd_sub(), 1'b1, 17, -1);
      data_island_period = 1'b0;
      #1;
      chk("drop_load", 64'(packet_load), 64'd0);
      tick();
      chk("drop_data", 64'(packet_data), 64'd0);
      chk("drop_end", 64'(packet_end), 64'd0);
      chk("drop_counter", 64'(counter), 64'd0);
      tick();
      tick();
      run_packet(24'($urandom), rnd_sub(), 1'b0, 32, -1);

      // Asynchronous reset at counter 10 with the island open.
      run_packet(24'($urandom), rnd_sub(), 1'b0, 10, -1);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_counter", 64'(counter), 64'd0);
      chk("arst_data", 64'(packet_data), 64'd0);
      chk("arst_end", 64'(packet_end), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      run_packet(24'($urandom), rnd_sub(), 1'b1, 32, -1);
      run_packet(24'($urandom), rnd_sub(), 1'b0, 32, -1);

      data_island_period = 1'b0;
      tick();
      chk("close_data", 64'(packet_data), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
